// File: rtl/swerv_types.sv
// Shared LSU types: prioritised address-check fault causes and a range helper.
// Imported by the address-check pipeline and its window sub-module.
package swerv_types;

    typedef enum logic [2:0] {
        NONE         = 3'd0,
        DCCM_OFS     = 3'd1,
        PIC_OFS      = 3'd2,
        CCM_CROSS    = 3'd3,
        PIC_ALIGN    = 3'd4,
        NO_WIN       = 3'd5,
        REGION_CROSS = 3'd6,
        SE_ALIGN     = 3'd7
    } fault_cause_e;

    // True when addr lies in the naturally aligned block at base covered by mask.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
        return (addr & ~mask) == (base & ~mask);
    endfunction

endpackage

// File: rtl/lsu_addrcheck_pipe_if.sv
// DC1 request bus and DC2/DC3 check results between address generation and the
// LSU fault logic. master = request producer, slave = address checker.
interface lsu_addrcheck_pipe_if;

    logic        req_valid_dc1;
    logic        dma_dc1;
    logic [31:0] start_addr_dc1;
    logic [31:0] end_addr_dc1;
    logic [1:0]  size_dc1;

    logic        addr_in_dccm_dc1;
    logic        addr_in_pic_dc1;
    logic        addr_external_dc1;
    logic        valid_dc2;
    logic        access_fault_dc2;
    logic        misaligned_fault_dc2;
    logic [2:0]  fault_cause_dc2;
    logic        is_sideeffects_dc2;
    logic        is_sideeffects_dc3;

    modport master (
        output req_valid_dc1, dma_dc1, start_addr_dc1, end_addr_dc1, size_dc1,
        input  addr_in_dccm_dc1, addr_in_pic_dc1, addr_external_dc1,
               valid_dc2, access_fault_dc2, misaligned_fault_dc2,
               fault_cause_dc2, is_sideeffects_dc2, is_sideeffects_dc3
    );

    modport slave (
        input  req_valid_dc1, dma_dc1, start_addr_dc1, end_addr_dc1, size_dc1,
        output addr_in_dccm_dc1, addr_in_pic_dc1, addr_external_dc1,
               valid_dc2, access_fault_dc2, misaligned_fault_dc2,
               fault_cause_dc2, is_sideeffects_dc2, is_sideeffects_dc3
    );

endinterface

// File: rtl/lsu_addrcheck_win.sv
// One CSR-programmable data-access window: addr/mask/enable registers plus the
// start/end address match. Optional write lock under LSU_ADDRCHECK_LOCK_EN.
module lsu_addrcheck_win
    import swerv_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_mask,
    input  logic        wr_enable,
    input  logic        wr_lock,
    input  logic [31:0] start_addr,
    input  logic [31:0] end_addr,
    output logic        enabled,
    output logic        start_match,
    output logic        end_match
);

    logic [31:0] addr_q, addr_d;
    logic [31:0] mask_q, mask_d;
    logic        en_q, en_d;
    logic        wr_ok;

`ifdef LSU_ADDRCHECK_LOCK_EN
    logic lock_q, lock_d;

    // The locking write itself still lands; only later writes are blocked.
    assign wr_ok = wr_en & ~lock_q;

    always_comb begin
        lock_d = lock_q;
        if (wr_ok && wr_lock) begin
            lock_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    logic unused_wr_lock;

    assign unused_wr_lock = wr_lock;
    assign wr_ok          = wr_en;
`endif

    always_comb begin
        addr_d = addr_q;
        mask_d = mask_q;
        en_d   = en_q;
        if (wr_ok) begin
            addr_d = wr_addr;
            mask_d = wr_mask;
            en_d   = wr_enable;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= 32'h0;
            mask_q <= 32'h0;
            en_q   <= 1'b0;
        end else begin
            addr_q <= addr_d;
            mask_q <= mask_d;
            en_q   <= en_d;
        end
    end

    assign enabled     = en_q;
    assign start_match = en_q && ((start_addr | mask_q) == (addr_q | mask_q));
    assign end_match   = en_q && ((end_addr   | mask_q) == (addr_q | mask_q));

endmodule

// File: rtl/lsu_addrcheck_pipe.sv
// Registered LSU memory-map checker: DC1 classification, window check and
// prioritised fault cause into DC2, side-effect into DC3. Optional macro: LSU_ADDRCHECK_LOCK_EN.
module lsu_addrcheck_pipe
    import swerv_types::*;
#(
    parameter int          NUM_WIN   = 8,
    parameter logic [31:0] DCCM_SADR = 32'hF004_0000,
    parameter int          DCCM_SIZE = 64,
    parameter logic [31:0] PIC_SADR  = 32'hF00C_0000,
    parameter int          PIC_SIZE  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    lsu_addrcheck_pipe_if.slave    lsu,
    input  logic [31:0]            mrac,
    input  logic                   win_wr_en,
    input  logic [(NUM_WIN > 1 ? $clog2(NUM_WIN) : 1)-1:0] win_wr_idx,
    input  logic [31:0]            win_wr_addr,
    input  logic [31:0]            win_wr_mask,
    input  logic                   win_wr_enable,
    input  logic                   win_wr_lock,
    output logic [15:0]            fault_cnt,
    input  logic                   fault_cnt_clr
);

    localparam int          IDX_W     = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
    localparam logic [31:0] DCCM_MASK = 32'(DCCM_SIZE * 1024 - 1);
    localparam logic [31:0] PIC_MASK  = 32'(PIC_SIZE * 1024 - 1);

    logic [31:0] start_addr, end_addr;

    logic s_dccm_rng, e_dccm_rng, s_pic_rng, e_pic_rng;
    logic s_dccm_reg, e_dccm_reg, s_pic_reg, e_pic_reg;
    logic in_dccm, in_pic, external;
    logic misaligned, se_dc1, win_pass, req_checked;

    logic [NUM_WIN-1:0] win_en, win_s_match, win_e_match;

    fault_cause_e cause_raw, cause_d, cause_q;
    logic         valid_dc2_d, valid_dc2_q;
    logic         access_fault_d, access_fault_q;
    logic         misaligned_fault_d, misaligned_fault_q;
    logic         se_dc2_d, se_dc2_q;
    logic         se_dc3_d, se_dc3_q;
    logic [15:0]  fault_cnt_d, fault_cnt_q;

    assign start_addr = lsu.start_addr_dc1;
    assign end_addr   = lsu.end_addr_dc1;

    for (genvar i = 0; i < NUM_WIN; i++) begin : g_win
        lsu_addrcheck_win u_win (
            .clk         (clk),
            .rst         (rst),
            .wr_en       (win_wr_en && (win_wr_idx == IDX_W'(i))),
            .wr_addr     (win_wr_addr),
            .wr_mask     (win_wr_mask),
            .wr_enable   (win_wr_enable),
            .wr_lock     (win_wr_lock),
            .start_addr  (start_addr),
            .end_addr    (end_addr),
            .enabled     (win_en[i]),
            .start_match (win_s_match[i]),
            .end_match   (win_e_match[i])
        );
    end

    assign s_dccm_rng = in_range(start_addr, DCCM_SADR, DCCM_MASK);
    assign e_dccm_rng = in_range(end_addr,   DCCM_SADR, DCCM_MASK);
    assign s_pic_rng  = in_range(start_addr, PIC_SADR,  PIC_MASK);
    assign e_pic_rng  = in_range(end_addr,   PIC_SADR,  PIC_MASK);

    assign s_dccm_reg = (start_addr[31:28] == DCCM_SADR[31:28]);
    assign e_dccm_reg = (end_addr[31:28]   == DCCM_SADR[31:28]);
    assign s_pic_reg  = (start_addr[31:28] == PIC_SADR[31:28]);
    assign e_pic_reg  = (end_addr[31:28]   == PIC_SADR[31:28]);

    assign in_dccm  = s_dccm_rng & e_dccm_rng;
    assign in_pic   = s_pic_rng & e_pic_rng;
    assign external = ~(in_dccm | in_pic);

    assign lsu.addr_in_dccm_dc1  = in_dccm;
    assign lsu.addr_in_pic_dc1   = in_pic;
    assign lsu.addr_external_dc1 = external;

    // With no window enabled the window check is transparent.
    assign win_pass = ~(|win_en) | ((|win_s_match) & (|win_e_match));

    assign se_dc1      = mrac[{start_addr[31:28], 1'b1}] & ~(s_dccm_reg | s_pic_reg);
    assign req_checked = lsu.req_valid_dc1 & ~lsu.dma_dc1;

    always_comb begin
        misaligned = 1'b0;
        case (lsu.size_dc1)
            2'd1:    misaligned = start_addr[0];
            2'd2:    misaligned = |start_addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    // An address in a region but in neither the DCCM nor the PIC block is an
    // offset fault; touching one block but not lying wholly inside it is a crossing.
    always_comb begin
        cause_raw = NONE;
        if ((s_dccm_reg & ~s_dccm_rng & ~s_pic_rng) |
            (e_dccm_reg & ~e_dccm_rng & ~e_pic_rng)) begin
            cause_raw = DCCM_OFS;
        end else if ((s_pic_reg & ~s_pic_rng & ~s_dccm_rng) |
                     (e_pic_reg & ~e_pic_rng & ~e_dccm_rng)) begin
            cause_raw = PIC_OFS;
        end else if ((s_dccm_rng | e_dccm_rng | s_pic_rng | e_pic_rng) & external) begin
            cause_raw = CCM_CROSS;
        end else if (in_pic & ((lsu.size_dc1 != 2'd2) | (|start_addr[1:0]))) begin
            cause_raw = PIC_ALIGN;
        end else if (~(s_dccm_reg | s_pic_reg) & ~win_pass) begin
            cause_raw = NO_WIN;
        end else if ((start_addr[31:28] != end_addr[31:28]) & external) begin
            cause_raw = REGION_CROSS;
        end else if (se_dc1 & misaligned & external) begin
            cause_raw = SE_ALIGN;
        end
        cause_d = req_checked ? cause_raw : NONE;
    end

    always_comb begin
        valid_dc2_d        = valid_dc2_q;
        access_fault_d     = access_fault_q;
        misaligned_fault_d = misaligned_fault_q;
        se_dc2_d           = se_dc2_q;
        se_dc3_d           = se_dc3_q;
        fault_cnt_d        = fault_cnt_q;
        if (!freeze) begin
            valid_dc2_d        = lsu.req_valid_dc1;
            access_fault_d     = (cause_d >= DCCM_OFS) && (cause_d <= NO_WIN);
            misaligned_fault_d = (cause_d >= REGION_CROSS);
            se_dc2_d           = se_dc1;
            se_dc3_d           = se_dc2_q;
            if ((cause_d != NONE) && (fault_cnt_q != 16'hFFFF)) begin
                fault_cnt_d = fault_cnt_q + 16'd1;
            end
        end
        if (fault_cnt_clr) begin
            fault_cnt_d = 16'h0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_dc2_q        <= 1'b0;
            cause_q            <= NONE;
            access_fault_q     <= 1'b0;
            misaligned_fault_q <= 1'b0;
            se_dc2_q           <= 1'b0;
            se_dc3_q           <= 1'b0;
            fault_cnt_q        <= 16'h0;
        end else begin
            valid_dc2_q        <= valid_dc2_d;
            cause_q            <= freeze ? cause_q : cause_d;
            access_fault_q     <= access_fault_d;
            misaligned_fault_q <= misaligned_fault_d;
            se_dc2_q           <= se_dc2_d;
            se_dc3_q           <= se_dc3_d;
            fault_cnt_q        <= fault_cnt_d;
        end
    end

    assign lsu.valid_dc2            = valid_dc2_q;
    assign lsu.access_fault_dc2     = access_fault_q;
    assign lsu.misaligned_fault_dc2 = misaligned_fault_q;
    assign lsu.fault_cause_dc2      = cause_q;
    assign lsu.is_sideeffects_dc2   = se_dc2_q;
    assign lsu.is_sideeffects_dc3   = se_dc3_q;
    assign fault_cnt                = fault_cnt_q;

endmodule

// File: tb/tb_lsu_addrcheck_pipe.sv
// Directed self-checking bench for lsu_addrcheck_pipe (NUM_WIN=6 so that an
// out-of-range window index can be exercised). Lock checks need LSU_ADDRCHECK_LOCK_EN.
module tb_lsu_addrcheck_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic [31:0] mrac = 32'h0;
    logic        win_wr_en = 1'b0;
    logic [2:0]  win_wr_idx = 3'd0;
    logic [31:0] win_wr_addr = 32'h0;
    logic [31:0] win_wr_mask = 32'h0;
    logic        win_wr_enable = 1'b0;
    logic        win_wr_lock = 1'b0;
    logic [15:0] fault_cnt;
    logic        fault_cnt_clr = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    lsu_addrcheck_pipe_if bus ();

    lsu_addrcheck_pipe #(.NUM_WIN(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .lsu           (bus),
        .mrac          (mrac),
        .win_wr_en     (win_wr_en),
        .win_wr_idx    (win_wr_idx),
        .win_wr_addr   (win_wr_addr),
        .win_wr_mask   (win_wr_mask),
        .win_wr_enable (win_wr_enable),
        .win_wr_lock   (win_wr_lock),
        .fault_cnt     (fault_cnt),
        .fault_cnt_clr (fault_cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input logic dma, input logic [31:0] s,
                                  input logic [31:0] e, input logic [1:0] size);
        bus.req_valid_dc1  = v;
        bus.dma_dc1        = dma;
        bus.start_addr_dc1 = s;
        bus.end_addr_dc1   = e;
        bus.size_dc1       = size;
    endtask

    task automatic win_write(input logic [2:0] idx, input logic [31:0] addr,
                             input logic [31:0] mask, input logic en, input logic lock);
        win_wr_en     = 1'b1;
        win_wr_idx    = idx;
        win_wr_addr   = addr;
        win_wr_mask   = mask;
        win_wr_enable = en;
        win_wr_lock   = lock;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_dc2(input string tag, input logic v, input logic af, input logic mf,
                             input logic [2:0] cause);
        check_output({tag, " valid"}, 32'(bus.valid_dc2), 32'(v));
        check_output({tag, " access"}, 32'(bus.access_fault_dc2), 32'(af));
        check_output({tag, " misal"}, 32'(bus.misaligned_fault_dc2), 32'(mf));
        check_output({tag, " cause"}, 32'(bus.fault_cause_dc2), 32'(cause));
    endtask

    initial begin
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        #1 rst = 1'b1;
        #1;
        check_dc2("reset", 1'b0, 1'b0, 1'b0, 3'd0);
        check_output("reset se2", 32'(bus.is_sideeffects_dc2), 32'h0);
        check_output("reset se3", 32'(bus.is_sideeffects_dc3), 32'h0);
        check_output("reset cnt", 32'(fault_cnt), 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // No window enabled: plain external word load passes.
        apply_stimulus(1'b1, 1'b0, 32'h0000_1000, 32'h0000_1003, 2'd2);
        #1;
        check_output("t1 ext", 32'(bus.addr_external_dc1), 32'h1);
        check_output("t1 dccm", 32'(bus.addr_in_dccm_dc1), 32'h0);
        tick();
        check_dc2("t1", 1'b1, 1'b0, 1'b0, 3'd0);

        // Window write in the same cycle as a request: request sees old windows.
        win_write(3'd0, 32'h2000_0000, 32'h0FFF_FFFF, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h3000_0000, 32'h3000_0003, 2'd2);
        tick();
        win_wr_en = 1'b0;
        check_dc2("prewrite", 1'b1, 1'b0, 1'b0, 3'd0);

        apply_stimulus(1'b1, 1'b0, 32'h3000_0000, 32'h3000_0003, 2'd2);
        tick();
        check_dc2("nowin", 1'b1, 1'b1, 1'b0, 3'd5);
        check_output("nowin cnt", 32'(fault_cnt), 32'd1);

        apply_stimulus(1'b1, 1'b0, 32'h2000_0010, 32'h2000_0013, 2'd2);
        tick();
        check_dc2("winhit", 1'b1, 1'b0, 1'b0, 3'd0);

        apply_stimulus(1'b1, 1'b0, 32'hF004_FFFE, 32'hF005_0001, 2'd2);
        #1;
        check_output("dccmofs in_dccm", 32'(bus.addr_in_dccm_dc1), 32'h0);
        tick();
        check_dc2("dccmofs", 1'b1, 1'b1, 1'b0, 3'd1);
        check_output("dccmofs cnt", 32'(fault_cnt), 32'd2);

        apply_stimulus(1'b1, 1'b0, 32'hF00C_0000, 32'hF00C_0001, 2'd1);
        #1;
        check_output("picalign in_pic", 32'(bus.addr_in_pic_dc1), 32'h1);
        check_output("picalign ext", 32'(bus.addr_external_dc1), 32'h0);
        tick();
        check_dc2("picalign", 1'b1, 1'b1, 1'b0, 3'd4);

        apply_stimulus(1'b1, 1'b1, 32'hF00C_0000, 32'hF00C_0001, 2'd1);
        tick();
        check_dc2("dma", 1'b1, 1'b0, 1'b0, 3'd0);
        check_output("dma cnt", 32'(fault_cnt), 32'd3);

        // Disable window 0; a write to index 6 (>= NUM_WIN) must be dropped.
        win_write(3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        win_write(3'd6, 32'h5000_0000, 32'h0FFF_FFFF, 1'b1, 1'b0);
        tick();
        win_wr_en = 1'b0;
        apply_stimulus(1'b1, 1'b0, 32'h3000_0000, 32'h3000_0003, 2'd2);
        tick();
        check_dc2("idxoor", 1'b1, 1'b0, 1'b0, 3'd0);

        mrac = 32'h0000_8000;
        apply_stimulus(1'b1, 1'b0, 32'h7000_0001, 32'h7000_0002, 2'd1);
        tick();
        check_dc2("sealign", 1'b1, 1'b0, 1'b1, 3'd7);
        check_output("sealign se2", 32'(bus.is_sideeffects_dc2), 32'h1);
        check_output("sealign se3", 32'(bus.is_sideeffects_dc3), 32'h0);
        check_output("sealign cnt", 32'(fault_cnt), 32'd4);
        tick();
        check_output("sealign se3 late", 32'(bus.is_sideeffects_dc3), 32'h1);
        check_output("sealign cnt2", 32'(fault_cnt), 32'd5);

        // Freeze holds DC2/DC3 and the counter, while a window write still lands.
        freeze = 1'b1;
        apply_stimulus(1'b1, 1'b0, 32'h0000_1000, 32'h0000_1003, 2'd2);
        win_write(3'd1, 32'h0, 32'h1FFF_FFFF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            win_wr_en = 1'b0;
            check_dc2("freeze", 1'b1, 1'b0, 1'b1, 3'd7);
            check_output("freeze se2", 32'(bus.is_sideeffects_dc2), 32'h1);
            check_output("freeze se3", 32'(bus.is_sideeffects_dc3), 32'h1);
            check_output("freeze cnt", 32'(fault_cnt), 32'd5);
        end
        freeze = 1'b0;

        apply_stimulus(1'b1, 1'b0, 32'h3000_0000, 32'h3000_0003, 2'd2);
        tick();
        check_dc2("frzwin", 1'b1, 1'b1, 1'b0, 3'd5);
        check_output("frzwin cnt", 32'(fault_cnt), 32'd6);

        apply_stimulus(1'b1, 1'b0, 32'h0FFF_FFFE, 32'h1000_0001, 2'd2);
        tick();
        check_dc2("regcross", 1'b1, 1'b0, 1'b1, 3'd6);
        check_output("regcross cnt", 32'(fault_cnt), 32'd7);

        // Clear beats a simultaneous increment.
        fault_cnt_clr = 1'b1;
        apply_stimulus(1'b1, 1'b0, 32'h3000_0000, 32'h3000_0003, 2'd2);
        tick();
        fault_cnt_clr = 1'b0;
        check_dc2("clr", 1'b1, 1'b1, 1'b0, 3'd5);
        check_output("clr cnt", 32'(fault_cnt), 32'd0);

        apply_stimulus(1'b0, 1'b0, 32'h3000_0000, 32'h3000_0003, 2'd2);
        tick();
        check_dc2("gated", 1'b0, 1'b0, 1'b0, 3'd0);
        check_output("gated cnt", 32'(fault_cnt), 32'd0);

`ifdef LSU_ADDRCHECK_LOCK_EN
        win_write(3'd1, 32'h0, 32'h1FFF_FFFF, 1'b1, 1'b1);
        tick();
        win_write(3'd1, 32'h4000_0000, 32'h0FFF_FFFF, 1'b1, 1'b0);
        tick();
        win_wr_en = 1'b0;
        apply_stimulus(1'b1, 1'b0, 32'h4000_0000, 32'h4000_0003, 2'd2);
        tick();
        check_output("lock keep", 32'(bus.fault_cause_dc2), 32'd5);
        apply_stimulus(1'b1, 1'b0, 32'h1000_0000, 32'h1000_0003, 2'd2);
        tick();
        check_output("lock old", 32'(bus.fault_cause_dc2), 32'd0);
`endif

        // Asynchronous reset mid-request drops DC2 immediately and clears windows.
        apply_stimulus(1'b1, 1'b0, 32'h2000_0010, 32'h2000_0013, 2'd2);
        tick();
        check_dc2("prerst", 1'b1, 1'b1, 1'b0, 3'd5);
        #2 rst = 1'b1;
        #1;
        check_dc2("asyncrst", 1'b0, 1'b0, 1'b0, 3'd0);
        check_output("asyncrst cnt", 32'(fault_cnt), 32'd0);
        #1 rst = 1'b0;
        tick();
        apply_stimulus(1'b1, 1'b0, 32'h3000_0000, 32'h3000_0003, 2'd2);
        tick();
        check_dc2("postrst", 1'b1, 1'b0, 1'b0, 3'd0);

`ifdef LSU_ADDRCHECK_LOCK_EN
        win_write(3'd1, 32'h4000_0000, 32'h0FFF_FFFF, 1'b1, 1'b0);
        tick();
        win_wr_en = 1'b0;
        apply_stimulus(1'b1, 1'b0, 32'h4000_0000, 32'h4000_0003, 2'd2);
        tick();
        check_output("unlock", 32'(bus.fault_cause_dc2), 32'd0);
        apply_stimulus(1'b1, 1'b0, 32'h1000_0000, 32'h1000_0003, 2'd2);
        tick();
        check_output("unlock new", 32'(bus.fault_cause_dc2), 32'd5);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
